cnn_inference_sequencer: RTL and testbench

//  Top-level control for one CNN inference. It launches the dense back-end engine for a selected image.
//  It then streams NUM_CLASSES signed scores out of the engine's result port and runs an in-line signed argmax.
//  It reports the winning class and its score.

---
 rtl/cnn_inference_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_cnn_inference_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_inference_sequencer.sv
// Launches the engine, streams NUM_CLASSES scores through a signed argmax; done = eng_done + NUM_CLASSES + 3 cycles, start ignored while busy.
// Optional CNN_SEQ_MARGIN_EN adds a top1-top2 margin output tracked alongside the argmax.
module cnn_inference_sequencer #(
   parameter int NUM_CLASSES = 9,
   parameter int DATA_W      = 32,
   parameter int IDX_W       = 5,
   parameter int CLS_W       = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [IDX_W-1:0]  image_index,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [CLS_W-1:0]  predicted_class,
   output logic [DATA_W-1:0] max_score,
`ifdef CNN_SEQ_MARGIN_EN
   output logic [DATA_W:0]   margin,
`endif
   output logic              eng_start,
   output logic [IDX_W-1:0]  eng_image_index,
   input  logic              eng_done,
   output logic [CLS_W-1:0]  eng_rd_addr,
   input  logic [DATA_W-1:0] eng_rd_data
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CLS_W-1:0] LAST_ADDR = CLS_W'(NUM_CLASSES - 1);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_WAIT, S_READ, S_DRAIN, S_FINISH
   } state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          img_q, img_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      to_q, to_d;
   logic [CLS_W-1:0]          addr_q, addr_d;
   logic                      rd_vld_q, rd_vld_d;
   logic [CLS_W-1:0]          rd_idx_q, rd_idx_d;
   logic [CLS_W-1:0]          best_idx_q, best_idx_d;
   logic signed [DATA_W-1:0]  best_val_q, best_val_d;
   logic                      done_q, done_d;
   logic                      timeout_q, timeout_d;
   logic [CLS_W-1:0]          pred_q, pred_d;
   logic [DATA_W-1:0]         max_q, max_d;
   logic signed [DATA_W-1:0]  score;
`ifdef CNN_SEQ_MARGIN_EN
   logic signed [DATA_W-1:0]  sec_val_q, sec_val_d;
   logic [DATA_W:0]           margin_q, margin_d;
`endif

   assign score = $signed(eng_rd_data);

   always_comb begin
      state_d   = state_q;
      img_d     = img_q;
      cnt_d     = cnt_q;
      to_d      = to_q;
      addr_d    = '0;
      done_d    = 1'b0;
      timeout_d = timeout_q;
      pred_d    = pred_q;
      max_d     = max_q;
`ifdef CNN_SEQ_MARGIN_EN
      margin_d  = margin_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               img_d   = image_index;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            to_d    = 1'b0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // eng_done has priority over a coincident timeout
            if (eng_done) begin
               state_d = S_READ;
            end else if (cnt_q == LAST_CNT) begin
               to_d    = 1'b1;
               state_d = S_FINISH;
            end
         end
         S_READ: begin
            if (addr_q == LAST_ADDR) begin
               state_d = S_DRAIN;
            end else begin
               addr_d = addr_q + CLS_W'(1);
            end
         end
         S_DRAIN: begin
            state_d = S_FINISH;
         end
         S_FINISH: begin
            done_d    = 1'b1;
            timeout_d = to_q;
            pred_d    = to_q ? '0 : best_idx_q;
            max_d     = to_q ? '0 : best_val_q;
`ifdef CNN_SEQ_MARGIN_EN
            margin_d  = to_q ? '0 : ({best_val_q[DATA_W-1], best_val_q} -
                                     {sec_val_q[DATA_W-1], sec_val_q});
`endif
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Argmax stage: sees the score for the address issued one cycle earlier
   always_comb begin
      rd_vld_d   = (state_q == S_READ);
      rd_idx_d   = addr_q;
      best_idx_d = best_idx_q;
      best_val_d = best_val_q;
`ifdef CNN_SEQ_MARGIN_EN
      sec_val_d  = sec_val_q;
`endif
      if (rd_vld_q) begin
         if (rd_idx_q == '0) begin
            best_idx_d = '0;
            best_val_d = score;
         end else if (score > best_val_q) begin
            best_idx_d = rd_idx_q;
            best_val_d = score;
`ifdef CNN_SEQ_MARGIN_EN
            sec_val_d  = best_val_q;
`endif
         end
`ifdef CNN_SEQ_MARGIN_EN
         else if ((rd_idx_q == CLS_W'(1)) || (score > sec_val_q)) begin
            sec_val_d = score;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         img_q      <= '0;
         cnt_q      <= '0;
         to_q       <= 1'b0;
         addr_q     <= '0;
         rd_vld_q   <= 1'b0;
         rd_idx_q   <= '0;
         best_idx_q <= '0;
         best_val_q <= '0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         pred_q     <= '0;
         max_q      <= '0;
`ifdef CNN_SEQ_MARGIN_EN
         sec_val_q  <= '0;
         margin_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         img_q      <= img_d;
         cnt_q      <= cnt_d;
         to_q       <= to_d;
         addr_q     <= addr_d;
         rd_vld_q   <= rd_vld_d;
         rd_idx_q   <= rd_idx_d;
         best_idx_q <= best_idx_d;
         best_val_q <= best_val_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
         pred_q     <= pred_d;
         max_q      <= max_d;
`ifdef CNN_SEQ_MARGIN_EN
         sec_val_q  <= sec_val_d;
         margin_q   <= margin_d;
`endif
      end
   end

   assign busy            = (state_q != S_IDLE);
   assign eng_start       = (state_q == S_LAUNCH);
   assign eng_image_index = img_q;
   assign eng_rd_addr     = addr_q;
   assign done            = done_q;
   assign timeout         = timeout_q;
   assign predicted_class = pred_q;
   assign max_score       = max_q;
`ifdef CNN_SEQ_MARGIN_EN
   assign margin          = margin_q;
`endif

endmodule

// File: tb/tb_cnn_inference_sequencer.sv
// Directed bench for cnn_inference_sequencer with a behavioural score-memory engine.
module tb_cnn_inference_sequencer;

   localparam int N  = 9;
   localparam int DW = 32;
   localparam int IW = 5;
   localparam int CW = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0;
   logic [IW-1:0] image_index = '0;
   logic          busy, done, timeout;
   logic [CW-1:0] predicted_class;
   logic [DW-1:0] max_score;
`ifdef CNN_SEQ_MARGIN_EN
   logic [DW:0]   margin;
`endif
   logic          eng_start;
   logic [IW-1:0] eng_image_index;
   logic          eng_done = 1'b0;
   logic [CW-1:0] eng_rd_addr;
   logic [DW-1:0] eng_rd_data = '0;

   logic [DW-1:0] mem [0:15];
   int            sc [9];
   int            n_checks = 0;
   int            n_fail = 0;
   int            n_eng_start = 0;
   int            n_done = 0;
   int            addr_viol = 0;

   cnn_inference_sequencer #(
      .NUM_CLASSES(N), .DATA_W(DW), .IDX_W(IW), .CLS_W(CW), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .image_index(image_index),
      .busy(busy), .done(done), .timeout(timeout),
      .predicted_class(predicted_class), .max_score(max_score),
`ifdef CNN_SEQ_MARGIN_EN
      .margin(margin),
`endif
      .eng_start(eng_start), .eng_image_index(eng_image_index),
      .eng_done(eng_done), .eng_rd_addr(eng_rd_addr), .eng_rd_data(eng_rd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) eng_rd_data <= mem[eng_rd_addr];

   always @(posedge clk) begin
      if (eng_start) n_eng_start <= n_eng_start + 1;
      if (done)      n_done      <= n_done + 1;
   end

   always @(negedge clk) if (eng_rd_addr > CW'(N - 1)) addr_viol <= addr_viol + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] sv32(input int v);
      logic [31:0] t;
      t = v;
      return {32'd0, t};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_scores();
      for (int i = 0; i < N; i++) mem[i] = DW'(sc[i]);
   endtask

   // Start in the current cycle, raise eng_done after dly WAIT cycles for hold cycles,
   // return cycles from the first eng_done sample to the done pulse.
   task automatic run_normal(input int idx, input int dly, input int hold, output int lat);
      int k;
      start = 1'b1;
      image_index = IW'(idx);
      step();
      start = 1'b0;
      expect_eq("launch_eng_start", 64'(eng_start), 64'(1));
      expect_eq("launch_img_idx", 64'(eng_image_index), 64'(idx));
      for (int i = 0; i < dly; i++) step();
      expect_eq("wait_eng_start_low", 64'(eng_start), 64'(0));
      eng_done = 1'b1;
      k = 0;
      while (!done && k < 60) begin
         step();
         k++;
         if (k == hold) eng_done = 1'b0;
      end
      eng_done = 1'b0;
      lat = k;
   endtask

   initial begin
      int lat;
      int k;
      int base;
      int dn;
      for (int i = 0; i < 16; i++) mem[i] = '0;

      // 1: reset and idle
      resetn = 1'b0;
      repeat (3) step();
      expect_eq("rst_busy", 64'(busy), 64'(0));
      expect_eq("rst_done", 64'(done), 64'(0));
      resetn = 1'b1;
      repeat (10) step();
      expect_eq("idle_busy", 64'(busy), 64'(0));
      expect_eq("idle_done", 64'(done), 64'(0));
      expect_eq("idle_timeout", 64'(timeout), 64'(0));
      expect_eq("idle_class", 64'(predicted_class), 64'(0));
      expect_eq("idle_score", 64'(max_score), 64'(0));
      expect_eq("idle_eng_img", 64'(eng_image_index), 64'(0));
      expect_eq("idle_rd_addr", 64'(eng_rd_addr), 64'(0));
      expect_eq("idle_eng_start_cnt", 64'(n_eng_start), 64'(0));
`ifdef CNN_SEQ_MARGIN_EN
      expect_eq("idle_margin", 64'(margin), 64'(0));
`endif

      // 2: mixed scores, tie on the maximum
      sc = '{5, -3, 17, 2, 17, 0, -8, 1, 4};
      load_scores();
      run_normal(7, 3, 1, lat);
      expect_eq("t2_latency", 64'(lat), 64'(N + 3));
      expect_eq("t2_class", 64'(predicted_class), 64'(2));
      expect_eq("t2_score", 64'(max_score), sv32(17));
      expect_eq("t2_timeout", 64'(timeout), 64'(0));
      expect_eq("t2_busy_at_done", 64'(busy), 64'(0));
      expect_eq("t2_eng_img", 64'(eng_image_index), 64'(7));
`ifdef CNN_SEQ_MARGIN_EN
      expect_eq("t2_margin", 64'(margin), 64'(0));
`endif
      step();
      expect_eq("t2_done_one_cycle", 64'(done), 64'(0));
      expect_eq("t2_class_held", 64'(predicted_class), 64'(2));

      // 3: all negative, eng_done held as a level
      sc = '{-9, -2, -50, -2, -7, -100, -3, -4, -5};
      load_scores();
      run_normal(5, 2, 12, lat);
      expect_eq("t3_latency", 64'(lat), 64'(N + 3));
      expect_eq("t3_class", 64'(predicted_class), 64'(1));
      expect_eq("t3_score", 64'(max_score), sv32(-2));
`ifdef CNN_SEQ_MARGIN_EN
      expect_eq("t3_margin", 64'(margin), 64'(0));
`endif

      // 4: engine never finishes
      step();
      start = 1'b1;
      image_index = 5'd9;
      step();
      start = 1'b0;
      k = 1;
      while (!done && k < 60) begin
         step();
         k++;
      end
      expect_eq("t4_timeout_latency", 64'(k), 64'(TO + 3));
      expect_eq("t4_timeout", 64'(timeout), 64'(1));
      expect_eq("t4_class", 64'(predicted_class), 64'(0));
      expect_eq("t4_score", 64'(max_score), 64'(0));
`ifdef CNN_SEQ_MARGIN_EN
      expect_eq("t4_margin", 64'(margin), 64'(0));
`endif
      step();
      sc = '{3, 9, 1, 0, 0, 0, 0, 0, 0};
      load_scores();
      run_normal(2, 1, 1, lat);
      expect_eq("t4b_latency", 64'(lat), 64'(N + 3));
      expect_eq("t4b_timeout", 64'(timeout), 64'(0));
      expect_eq("t4b_class", 64'(predicted_class), 64'(1));
      expect_eq("t4b_score", 64'(max_score), sv32(9));
`ifdef CNN_SEQ_MARGIN_EN
      expect_eq("t4b_margin", 64'(margin), 64'(6));
`endif

      // 5: start ignored while busy, then back-to-back
      step();
      sc = '{10, 20, -5, 30, 7, 29, 0, 1, 2};
      load_scores();
      base = n_eng_start;
      start = 1'b1;
      image_index = 5'd12;
      step();
      start = 1'b0;
      step();
      start = 1'b1;
      image_index = 5'd3;
      step();
      start = 1'b0;
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      step();
      start = 1'b1;
      image_index = 5'd4;
      step();
      start = 1'b0;
      expect_eq("t5_img_stable", 64'(eng_image_index), 64'(12));
      k = 0;
      while (!done && k < 60) begin
         step();
         k++;
      end
      expect_eq("t5_done_seen", 64'(done), 64'(1));
      expect_eq("t5_one_launch", 64'(n_eng_start - base), 64'(1));
      expect_eq("t5_class", 64'(predicted_class), 64'(3));
      expect_eq("t5_score", 64'(max_score), sv32(30));
`ifdef CNN_SEQ_MARGIN_EN
      expect_eq("t5_margin", 64'(margin), 64'(1));
`endif
      step();
      sc = '{-1, -1, -1, -1, -1, -1, -1, -1, 50};
      load_scores();
      run_normal(20, 1, 1, lat);
      expect_eq("t5b_latency", 64'(lat), 64'(N + 3));
      expect_eq("t5b_two_launches", 64'(n_eng_start - base), 64'(2));
      expect_eq("t5b_class", 64'(predicted_class), 64'(8));
      expect_eq("t5b_score", 64'(max_score), sv32(50));
`ifdef CNN_SEQ_MARGIN_EN
      expect_eq("t5b_margin", 64'(margin), 64'(51));
`endif

      // 6: reset in the middle of READ
      step();
      start = 1'b1;
      image_index = 5'd1;
      step();
      start = 1'b0;
      step();
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      step();
      step();
      expect_eq("t6_busy_in_read", 64'(busy), 64'(1));
      #2;
      resetn = 1'b0;
      #1;
      dn = n_done;
      expect_eq("t6_rst_busy", 64'(busy), 64'(0));
      expect_eq("t6_rst_addr", 64'(eng_rd_addr), 64'(0));
      expect_eq("t6_rst_class", 64'(predicted_class), 64'(0));
      expect_eq("t6_rst_score", 64'(max_score), 64'(0));
      expect_eq("t6_rst_done", 64'(done), 64'(0));
      expect_eq("t6_rst_eng_start", 64'(eng_start), 64'(0));
      expect_eq("t6_rst_eng_img", 64'(eng_image_index), 64'(0));
      repeat (3) step();
      resetn = 1'b1;
      repeat (2) step();
      expect_eq("t6_no_done_pulse", 64'(n_done), 64'(dn));
      expect_eq("t6_idle_after_rst", 64'(busy), 64'(0));
      sc = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
      load_scores();
      run_normal(2, 2, 1, lat);
      expect_eq("t6_latency", 64'(lat), 64'(N + 3));
      expect_eq("t6_class", 64'(predicted_class), 64'(8));
      expect_eq("t6_score", 64'(max_score), sv32(8));
      expect_eq("t6_timeout", 64'(timeout), 64'(0));
`ifdef CNN_SEQ_MARGIN_EN
      expect_eq("t6_margin", 64'(margin), 64'(1));
`endif

      step();
      expect_eq("total_done_pulses", 64'(n_done), 64'(7));
      expect_eq("total_eng_starts", 64'(n_eng_start), 64'(8));
      expect_eq("addr_range", 64'(addr_viol), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
